mc_control: RTL

- Moore-style main control FSM for the multicycle MIPS core.
- Sits directly upstream of the datapath: consumes opcode, func and zero, and drives every datapath control input.
- Each instruction is sequenced through fetch, decode, execute, memory and writeback states.
- Also produces PCEn, combining the unconditional PC write with the branch condition.

---
 rtl/mc_control_pkg.sv | 78 +++++++
 rtl/mc_control_if.sv | 36 +++
 rtl/mc_control_alu_decoder.sv | 24 ++
 rtl/mc_control.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
package mips_pkg;

    // FSM state encoding; values are visible on dbg_state for board display.
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_I_EXEC    = 4'd8,
        ST_I_WB      = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JUMP      = 4'd11
    } state_e;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    // PC source mux select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // ALU B operand mux select
    localparam logic [1:0] SRCB_RT  = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    // Full set of datapath control lines, bundled so reset gating is one expression.
    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [2:0] alu_sel;
        logic       illegal;
    } ctrl_t;

    // True for every opcode the core implements.
    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Datapath <-> main control bundle: instruction fields and flags in, control lines out.
interface mc_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic [5:0]         func;
    logic               zero;
    logic               PCEn;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               IRWrite;
    logic               RegWrite;
    logic               RegDst;
    logic               ALUSrcA;
    logic [1:0]         PCSource;
    logic [1:0]         ALUSrcB;
    logic [2:0]         ALUSel;
    logic               illegal;
    logic [STATE_W-1:0] dbg_state;

    // Datapath side: supplies instruction fields and the zero flag.
    modport master (
        output opcode, func, zero,
        input  PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
               RegDst, ALUSrcA, PCSource, ALUSrcB, ALUSel, illegal, dbg_state
    );

    // Control side: the FSM.
    modport slave (
        input  opcode, func, zero,
        output PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
               RegDst, ALUSrcA, PCSource, ALUSrcB, ALUSel, illegal, dbg_state
    );
endinterface

// File: rtl/mc_control_alu_decoder.sv
// Maps an R-type func field onto an ALU operation and flags unsupported codes.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] func_i,
    output logic [2:0] alu_sel_o,
    output logic       func_valid_o
);

    // Unsupported func falls back to ADD so the ALU still sees a defined op.
    always_comb begin
        alu_sel_o    = ALU_ADD;
        func_valid_o = 1'b1;
        case (func_i)
            F_ADD:   alu_sel_o = ALU_ADD;
            F_SUB:   alu_sel_o = ALU_SUB;
            F_AND:   alu_sel_o = ALU_AND;
            F_OR:    alu_sel_o = ALU_OR;
            F_SLT:   alu_sel_o = ALU_SLT;
            default: func_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Moore main control FSM for the multicycle MIPS core, including PC write enable.
module mc_control
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic         clk,
    input  logic         rst,      // active-low, asynchronous
    mc_control_if.slave  bus
);

    state_e     state_q;
    logic       is_bne_q;          // branch sense latched in DECODE
    logic       is_lw_q;           // lw vs sw latched in DECODE
    logic [2:0] dec_alu_sel;
    logic       dec_func_valid;
    logic       pc_write;
    logic       pc_write_cond;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;

    alu_decoder u_alu_dec (
        .func_i       (bus.func),
        .alu_sel_o    (dec_alu_sel),
        .func_valid_o (dec_func_valid)
    );

    // State sequencing; opcode is sampled only in DECODE, func only in R_EXEC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FETCH;
            is_bne_q <= 1'b0;
            is_lw_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH:  state_q <= ST_DECODE;
                ST_DECODE: begin
                    is_bne_q <= (bus.opcode == OP_BNE);
                    is_lw_q  <= (bus.opcode == OP_LW);
                    case (bus.opcode)
                        OP_RTYPE:      state_q <= ST_R_EXEC;
                        OP_LW, OP_SW:  state_q <= ST_MEM_ADDR;
                        OP_ADDI:       state_q <= ST_I_EXEC;
                        OP_BEQ, OP_BNE: state_q <= ST_BRANCH;
                        OP_J:          state_q <= ST_JUMP;
                        default:       state_q <= ST_FETCH;
                    endcase
                end
                ST_MEM_ADDR: state_q <= is_lw_q ? ST_MEM_READ : ST_MEM_WRITE;
                ST_MEM_READ: state_q <= ST_MEM_WB;
                ST_R_EXEC:   state_q <= dec_func_valid ? ST_R_WB : ST_FETCH;
                ST_I_EXEC:   state_q <= ST_I_WB;
                // MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH, JUMP and any
                // unreachable encoding all return to FETCH.
                default:     state_q <= ST_FETCH;
            endcase
        end
    end

    // Control decode of the current state; PCEn folds in the branch condition.
    always_comb begin
        ctrl          = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_sel   = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                pc_write       = 1'b1;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_sel   = ALU_ADD;
                ctrl.illegal   = !op_is_legal(bus.opcode);
            end
            ST_MEM_ADDR, ST_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_sel   = ALU_ADD;
            end
            ST_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_sel   = dec_alu_sel;
                ctrl.illegal   = !dec_func_valid;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_sel   = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                pc_write_cond  = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                pc_write       = 1'b1;
            end
            default: ;
        endcase
        ctrl.pc_en = pc_write | (pc_write_cond & (bus.zero ^ is_bne_q));
    end

    // Reset holds every control line low even though the state reads FETCH.
    assign ctrl_out = rst ? ctrl : '0;

    assign bus.PCEn      = ctrl_out.pc_en;
    assign bus.IorD      = ctrl_out.iord;
    assign bus.MemRead   = ctrl_out.mem_read;
    assign bus.MemWrite  = ctrl_out.mem_write;
    assign bus.MemtoReg  = ctrl_out.mem_to_reg;
    assign bus.IRWrite   = ctrl_out.ir_write;
    assign bus.RegWrite  = ctrl_out.reg_write;
    assign bus.RegDst    = ctrl_out.reg_dst;
    assign bus.ALUSrcA   = ctrl_out.alu_src_a;
    assign bus.PCSource  = ctrl_out.pc_source;
    assign bus.ALUSrcB   = ctrl_out.alu_src_b;
    assign bus.ALUSel    = ctrl_out.alu_sel;
    assign bus.illegal   = ctrl_out.illegal;
    assign bus.dbg_state = STATE_W'(state_q);

endmodule
